next_pc_unit: RTL

- Consumer end of the branch-offset path: takes the 30-bit sign-extended, word-scaled immediate from the sign extender and owns the program counter register for the single-cycle processor.
- Computes and registers the next fetch address from the following sources: sequential, taken conditional branch, absolute jump, or hold.
- Adds a small run-control state machine (boot, run, halted) and a stall handshake.
- Sits between the control unit/ALU zero flag and instruction memory.

---
 rtl/next_pc_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/next_pc_unit.sv
// next_pc_unit: program counter register and next-fetch-address select for the
// single-cycle core, with a boot/run/halted run-control FSM and a stall hold.
// Optional build macro NEXT_PC_BRANCH_STATS_EN adds taken-branch statistics
// outputs (taken_count, last_branch_pc).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_BOOT   | one cycle after reset, pc held at reset vector, no fetch
// ST_RUN    | fetching; pc advances by halt/stall/jump/branch/seq priority
// ST_HALTED | core stopped, pc frozen, only rst leaves this state
module next_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] imm16_ext,
  input  logic [25:0] target26,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        halt,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted
`ifdef NEXT_PC_BRANCH_STATS_EN
  ,
  output logic [31:0] taken_count,
  output logic [31:0] last_branch_pc
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [29:0] RESET_W = RESET_VECTOR[31:2];

  state_t      state_q, state_d;
  logic [29:0] pc_w, pc_w_d;
  logic [29:0] seq_w, br_w, jmp_w;

  // Candidate next word addresses; all arithmetic wraps modulo 2^30 words.
  always_comb begin
    seq_w = pc_w + 30'd1;
    br_w  = seq_w + imm16_ext;
    jmp_w = {seq_w[29:26], target26};
  end

  // Run-control next state and next pc selection.
  always_comb begin
    state_d = state_q;
    pc_w_d  = pc_w;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (stall) begin
          pc_w_d = pc_w;
        end else if (jump) begin
          pc_w_d = jmp_w;
        end else if (branch && zero) begin
          pc_w_d = br_w;
        end else begin
          pc_w_d = seq_w;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_BOOT;
        pc_w_d  = RESET_W;
      end
    endcase
  end

  // State and pc registers; reset wins over every control input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_w    <= RESET_W;
    end else begin
      state_q <= state_d;
      pc_w    <= pc_w_d;
    end
  end

  // Outputs decoded from registered state so they change on the deciding edge.
  always_comb begin
    pc          = {pc_w, 2'b00};
    pc_plus4    = {seq_w, 2'b00};
    fetch_valid = (state_q == ST_RUN);
    halted      = (state_q == ST_HALTED);
  end

`ifdef NEXT_PC_BRANCH_STATS_EN
  logic br_taken;

  // A branch counts only when it actually steers the pc (no halt/stall/jump).
  always_comb begin
    br_taken = (state_q == ST_RUN) && !halt && !stall && !jump && branch && zero;
  end

  // Saturating taken-branch counter and address of the latest taken branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_count    <= 32'd0;
      last_branch_pc <= 32'd0;
    end else if (br_taken) begin
      if (taken_count != 32'hFFFF_FFFF) begin
        taken_count <= taken_count + 32'd1;
      end
      last_branch_pc <= pc;
    end
  end
`endif

endmodule
